// File: rtl/mem_lsu.sv
// RV32I load/store unit feeding a word-only data RAM. Loads are extracted
// combinationally; SB/SH are done as a read cycle (stalled) then a merge write.
module mem_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_100MHz,
  input  logic              arst_n,
  input  logic              req_valid_i,
  input  logic              req_store_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              ram_r_ena_o,
  output logic [ADDR_W-1:0] ram_r_addr_o,
  input  logic [DATA_W-1:0] ram_r_data_i,
  output logic              ram_w_ena_o,
  output logic [ADDR_W-1:0] ram_w_addr_o,
  output logic [DATA_W-1:0] ram_w_data_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              stall_o,
  output logic              misalign_o
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MERGE = 1'b1} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_merge;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_data;

  logic              w_is_b;
  logic              w_is_h;
  logic              w_is_w;
  logic              w_legal;
  logic              w_misalign;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_lane_mask;
  logic [4:0]        w_shift;
  logic [DATA_W-1:0] w_merge;

  assign w_is_b     = (req_funct3_i == 3'b000) | (req_funct3_i == 3'b100);
  assign w_is_h     = (req_funct3_i == 3'b001) | (req_funct3_i == 3'b101);
  assign w_is_w     = (req_funct3_i == 3'b010);
  assign w_legal    = req_valid_i & (w_is_b | w_is_h | w_is_w);
  assign w_misalign = req_valid_i & ((w_is_w & (req_addr_i[1:0] != 2'b00)) |
                                     (w_is_h & req_addr_i[0]));

  // Lane extraction and sign/zero extension of the RAM word for loads
  always_comb begin
    case (req_addr_i[1:0])
      2'd0:    w_byte = ram_r_data_i[7:0];
      2'd1:    w_byte = ram_r_data_i[15:8];
      2'd2:    w_byte = ram_r_data_i[23:16];
      2'd3:    w_byte = ram_r_data_i[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = req_addr_i[1] ? ram_r_data_i[31:16] : ram_r_data_i[15:0];
    case (req_funct3_i)
      3'b000:  w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
      3'b100:  w_load = {{(DATA_W-8){1'b0}}, w_byte};
      3'b001:  w_load = {{(DATA_W-16){w_half[15]}}, w_half};
      3'b101:  w_load = {{(DATA_W-16){1'b0}}, w_half};
      3'b010:  w_load = ram_r_data_i;
      default: w_load = {DATA_W{1'b0}};
    endcase
  end

  // Read-modify-write merge: replace the addressed byte/half of the read word
  always_comb begin
    if (w_is_b) begin
      w_lane_mask = {{(DATA_W-8){1'b0}}, 8'hFF};
      w_shift     = {req_addr_i[1:0], 3'b000};
    end else begin
      w_lane_mask = {{(DATA_W-16){1'b0}}, 16'hFFFF};
      w_shift     = {req_addr_i[1], 4'b0000};
    end
    w_merge = (ram_r_data_i & ~(w_lane_mask << w_shift)) |
              ((req_wdata_i & w_lane_mask) << w_shift);
  end

  // Output decode; idle write port replays the last committed write for the RAM bypass
  always_comb begin
    ram_r_ena_o  = 1'b0;
    ram_r_addr_o = {ADDR_W{1'b0}};
    ram_w_ena_o  = 1'b0;
    ram_w_addr_o = r_hold_addr;
    ram_w_data_o = r_hold_data;
    load_data_o  = {DATA_W{1'b0}};
    stall_o      = 1'b0;
    misalign_o   = 1'b0;
    if (!arst_n) begin
      ram_w_addr_o = {ADDR_W{1'b0}};
      ram_w_data_o = {DATA_W{1'b0}};
    end else if (r_state == S_MERGE) begin
      ram_w_ena_o  = 1'b1;
      ram_w_addr_o = r_addr;
      ram_w_data_o = r_merge;
    end else if (w_misalign) begin
      misalign_o = 1'b1;
    end else if (w_legal) begin
      if (!req_store_i) begin
        ram_r_ena_o  = 1'b1;
        ram_r_addr_o = req_addr_i;
        load_data_o  = w_load;
      end else if (w_is_w) begin
        ram_w_ena_o  = 1'b1;
        ram_w_addr_o = req_addr_i;
        ram_w_data_o = req_wdata_i;
      end else begin
        ram_r_ena_o  = 1'b1;
        ram_r_addr_o = req_addr_i;
        stall_o      = 1'b1;
      end
    end else begin
      // no request or reserved funct3: defaults stand
      misalign_o = 1'b0;
    end
  end

  // State, merge capture and write-port hold registers
  always_ff @(posedge clk_100MHz) begin
    if (!arst_n) begin
      r_state     <= S_IDLE;
      r_merge     <= {DATA_W{1'b0}};
      r_addr      <= {ADDR_W{1'b0}};
      r_hold_addr <= {ADDR_W{1'b0}};
      r_hold_data <= {DATA_W{1'b0}};
    end else begin
      if (ram_w_ena_o) begin
        r_hold_addr <= ram_w_addr_o;
        r_hold_data <= ram_w_data_o;
      end
      case (r_state)
        S_IDLE: begin
          if (stall_o) begin
            r_merge <= w_merge;
            r_addr  <= {req_addr_i[ADDR_W-1:2], 2'b00};
            r_state <= S_MERGE;
          end
        end
        S_MERGE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
